pipeline_ctrl_seq: RTL
======================

# pipeline_ctrl_seq

Parametrised, sequential successor to the combinational pipeline stall/flush controller. It resolves `NUM_REQ` prioritised hazard requests into per-stage stall/flush vectors for a `NUM_STAGES`-deep pipeline, using parameter-supplied lookup maps. It adds a reset-flush sequencer, a trap drain/redirect FSM that waits for outstanding memory traffic, a stall watchdog and a stall-cycle performance counter. It sits beside the pipeline registers and drives every stage's stall/flush inputs.

## Interface
Parameters:
- `NUM_STAGES`, 6: pipeline register stages; bit 0 = PC, bit `NUM_STAGES-1` = MEM_WB.
- `NUM_REQ`, 7: hazard request sources; a higher index has higher priority.
- `STALL_MAP`, package default: `NUM_REQ*NUM_STAGES` bits; slice `[i*NUM_STAGES +: NUM_STAGES]` is the stall vector for request i.
- `FLUSH_MAP`, package default: same layout, holding the flush vector for request i.
- `RST_FLUSH_CYC`, 2: cycles of full flush after reset; must be ≥1.
- `WDOG_LIMIT`, 1024: consecutive PC-stall cycles before the watchdog fires; must be ≥1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_i`  in  `NUM_REQ`  level hazard requests.
- `trap_req_i`  in  1  trap/exception from WB, sampled at the clock edge.
- `mem_busy_i`  in  1  data-memory transaction outstanding.
- `stall_o`  out  `NUM_STAGES`  per-stage stall.
- `flush_o`  out  `NUM_STAGES`  per-stage flush.
- `redirect_o`  out  1  one-cycle pulse; PC takes the trap vector.
- `win_valid_o`  out  1  a request won this cycle.
- `win_idx_o`  out  `$clog2(NUM_REQ)`  index of the winning request; 0 when `win_valid_o`=0.
- `wdog_o`  out  1  sticky hang flag.
- `stall_cnt_o`  out  32  count of cycles with `stall_o[0]`=1.

## Operation
States: `S_RESET`, `S_RUN`, `S_DRAIN`, `S_REDIRECT`. The state is registered; outputs are combinational from the state and the inputs.
- **Reset values:** `rst`=1 forces `S_RESET`, rst-counter=0, wdog counter=0, `wdog_o`=0, `stall_cnt_o`=0. `rst` has priority over any in-flight trap.
- **`S_RESET`:** `stall_o`=0, `flush_o`=all ones, `redirect_o`=0, `win_valid_o`=0. Leave after `RST_FLUSH_CYC` cycles counted from the first cycle with `rst`=0; go to `S_RUN`.
- **`S_RUN`, no trap:**
  - Winner = highest set index of `req_i`.
  - `stall_o`/`flush_o` = that request's map slices.
  - No request gives all zeros and `win_valid_o`=0.
- **`S_RUN` with `trap_req_i`=1:**
  - Overrides all requests: `stall_o`=all ones, `flush_o`=0, `win_valid_o`=0.
  - Next state is `S_DRAIN` if `mem_busy_i`=1, else `S_REDIRECT`.
- **`S_DRAIN`:** `stall_o`=all ones, `flush_o`=0. Go to `S_REDIRECT` on the first edge where `mem_busy_i`=0.
- **`S_REDIRECT`:** exactly one cycle.
  - `stall_o`=0, `flush_o`=all ones except bit 0, `redirect_o`=1.
  - Then return to `S_RUN`.
- **Ignored inputs:** `req_i` and `trap_req_i` are ignored in `S_RESET`, `S_DRAIN` and `S_REDIRECT`. The trap source must hold or re-present.
- **Watchdog:**
  - The counter increments each cycle `stall_o[0]`=1 and clears when it is 0. It saturates at `WDOG_LIMIT`.
  - `wdog_o` sets on the cycle after the count reaches `WDOG_LIMIT` and stays set until `rst`.
- **`stall_cnt_o`:** increments, wrapping modulo 2^32, on every cycle with `stall_o[0]`=1 in any state.

## Timing
- Request-to-output latency is 0 cycles (combinational in `S_RUN`).
- Trap with memory idle: T0 all-stall, T1 redirect/flush, T2 normal.
- Trap with memory busy: all-stall for every busy cycle plus T0. Redirect comes on the cycle after the cycle `mem_busy_i` is first sampled 0.
- `redirect_o` is never high for 2 consecutive cycles.
- Simultaneous `trap_req_i` and `req_i` in `S_RUN`: the trap wins.
- Simultaneous requests: only the highest index's maps apply; maps are never ORed.
- `rst` asserted mid-`S_DRAIN`: `S_RESET` is entered the next cycle, and the pending trap is lost.
- Counter widths are `$clog2(RST_FLUSH_CYC+1)` and `$clog2(WDOG_LIMIT+1)`.

## Structure
- **Package `pipe_ctrl_pkg`:**
  - State enum.
  - Stage-index localparams (PC, PRE_IF, IF_ID, ID_EX, EX_MEM, MEM_WB).
  - Request-index localparams: compress=0, load_use=1, mul_div=2, jump=3, trap_csr=4, ram_if=5, ram_mem=6.
  - Default `STALL_MAP`/`FLUSH_MAP` encoding the current 6-stage policy.
- **Sub-module `pipe_req_arbiter`:** combinational priority encoder plus map slice select, producing winner, index and vectors. The top level holds the FSM and the counters.

## Test plan
- **Reset sequence:** `rst` high 3 cycles then low, with `RST_FLUSH_CYC`=2 -> `flush_o`=6'b111111 on every `rst` cycle and 2 more, then 0; `stall_o`=0 throughout.
- **Priority:** `req_i`=7'b0001010 -> `win_idx_o`=3 and the jump maps (stall 6'b000010, flush 6'b001110). Then `req_i`=7'b1000001 -> idx 6, stall 6'b011111, flush 6'b100000.
- **Trap, memory idle:** `trap_req_i` 1 cycle, `mem_busy_i`=0, with `req_i`=7'b0000010 -> T0 stall 6'b111111; T1 flush 6'b111110 and `redirect_o`=1; T2 load-use maps again.
- **Trap, memory busy:** `mem_busy_i` high for 4 cycles after the trap -> 5 all-stall cycles, then a single redirect; a `trap_req_i` re-pulse during drain has no effect.
- **Watchdog:** `WDOG_LIMIT`=8, hold `req_i[2]` -> `wdog_o`=0 for the first 8 cycles, 1 from cycle 9, still 1 after the request drops; `stall_cnt_o`=count of held cycles.
- **Reset mid-drain:** `rst` during `S_DRAIN` -> next cycle all-flush, no `redirect_o` ever, and `wdog_o`/`stall_cnt_o`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types, stage/request indices and default hazard maps for
//            the sequential pipeline stall/flush controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  localparam int c_STG_PC     = 0;
  localparam int c_STG_PRE_IF = 1;
  localparam int c_STG_IF_ID  = 2;
  localparam int c_STG_ID_EX  = 3;
  localparam int c_STG_EX_MEM = 4;
  localparam int c_STG_MEM_WB = 5;

  localparam int c_REQ_COMPRESS = 0;
  localparam int c_REQ_LOAD_USE = 1;
  localparam int c_REQ_MUL_DIV  = 2;
  localparam int c_REQ_JUMP     = 3;
  localparam int c_REQ_TRAP_CSR = 4;
  localparam int c_REQ_RAM_IF   = 5;
  localparam int c_REQ_RAM_MEM  = 6;

  // Six-stage policy; leftmost slice is request 6 (ram_mem), rightmost request 0.
  localparam logic [41:0] c_DEFAULT_STALL_MAP = {
    6'b011111, 6'b000011, 6'b001111, 6'b000010,
    6'b001111, 6'b000111, 6'b000011
  };
  localparam logic [41:0] c_DEFAULT_FLUSH_MAP = {
    6'b100000, 6'b000100, 6'b010000, 6'b001110,
    6'b010000, 6'b001000, 6'b000100
  };

endpackage
`default_nettype wire

// File: rtl/pipe_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_req_arbiter
// Brief    : Priority encoder over hazard requests (highest index wins) with
//            stall/flush map slice selection for the winner.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_req_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int NUM_REQ    = 7,
  parameter int IDX_W      = 3,
  parameter logic [NUM_REQ*NUM_STAGES-1:0] STALL_MAP = c_DEFAULT_STALL_MAP,
  parameter logic [NUM_REQ*NUM_STAGES-1:0] FLUSH_MAP = c_DEFAULT_FLUSH_MAP
) (
  input  logic [NUM_REQ-1:0]    i_req,
  output logic                  o_win_valid,
  output logic [IDX_W-1:0]      o_win_idx,
  output logic [NUM_STAGES-1:0] o_win_stall,
  output logic [NUM_STAGES-1:0] o_win_flush
);

  // Ascending scan so the last (highest) set request overwrites lower ones.
  always_comb begin
    o_win_valid = 1'b0;
    o_win_idx   = '0;
    o_win_stall = '0;
    o_win_flush = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req[i]) begin
        o_win_valid = 1'b1;
        o_win_idx   = IDX_W'(i);
        o_win_stall = STALL_MAP[i*NUM_STAGES +: NUM_STAGES];
        o_win_flush = FLUSH_MAP[i*NUM_STAGES +: NUM_STAGES];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_seq
// Brief    : Sequential pipeline stall/flush controller with reset flush,
//            trap drain/redirect FSM, stall watchdog and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int NUM_REQ    = 7,
  parameter logic [NUM_REQ*NUM_STAGES-1:0] STALL_MAP = c_DEFAULT_STALL_MAP,
  parameter logic [NUM_REQ*NUM_STAGES-1:0] FLUSH_MAP = c_DEFAULT_FLUSH_MAP,
  parameter int RST_FLUSH_CYC = 2,
  parameter int WDOG_LIMIT    = 1024,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic                  trap_req_i,
  input  logic                  mem_busy_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  redirect_o,
  output logic                  win_valid_o,
  output logic [IDX_W-1:0]      win_idx_o,
  output logic                  wdog_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int RST_CNT_W = $clog2(RST_FLUSH_CYC + 1);
  localparam int WD_W      = $clog2(WDOG_LIMIT + 1);
  localparam logic [RST_CNT_W-1:0]  c_RST_LAST       = RST_CNT_W'(RST_FLUSH_CYC - 1);
  localparam logic [WD_W-1:0]       c_WDOG_MAX       = WD_W'(WDOG_LIMIT);
  localparam logic [NUM_STAGES-1:0] c_REDIRECT_FLUSH = {{(NUM_STAGES-1){1'b1}}, 1'b0};

  state_t                r_state;
  logic [RST_CNT_W-1:0]  r_rst_cnt;
  logic [WD_W-1:0]       r_wdog_cnt;
  logic [WD_W-1:0]       w_wdog_cnt_nxt;
  logic                  r_wdog;
  logic [31:0]           r_stall_cnt;

  logic                  w_arb_valid;
  logic [IDX_W-1:0]      w_arb_idx;
  logic [NUM_STAGES-1:0] w_arb_stall;
  logic [NUM_STAGES-1:0] w_arb_flush;

  pipe_req_arbiter #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_REQ    (NUM_REQ),
    .IDX_W      (IDX_W),
    .STALL_MAP  (STALL_MAP),
    .FLUSH_MAP  (FLUSH_MAP)
  ) u_arb (
    .i_req       (req_i),
    .o_win_valid (w_arb_valid),
    .o_win_idx   (w_arb_idx),
    .o_win_stall (w_arb_stall),
    .o_win_flush (w_arb_flush)
  );

  always_comb begin
    stall_o     = '0;
    flush_o     = '0;
    redirect_o  = 1'b0;
    win_valid_o = 1'b0;
    win_idx_o   = '0;
    case (r_state)
      S_RESET: flush_o = '1;
      S_RUN: begin
        if (trap_req_i) begin
          stall_o = '1;
        end else begin
          stall_o     = w_arb_stall;
          flush_o     = w_arb_flush;
          win_valid_o = w_arb_valid;
          win_idx_o   = w_arb_idx;
        end
      end
      S_DRAIN: stall_o = '1;
      S_REDIRECT: begin
        flush_o    = c_REDIRECT_FLUSH;
        redirect_o = 1'b1;
      end
      default: flush_o = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RESET;
      r_rst_cnt <= '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (r_rst_cnt == c_RST_LAST) begin
            r_state   <= S_RUN;
            r_rst_cnt <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RST_CNT_W'(1);
          end
        end
        S_RUN: begin
          if (trap_req_i) begin
            r_state <= mem_busy_i ? S_DRAIN : S_REDIRECT;
          end
        end
        S_DRAIN: begin
          if (!mem_busy_i) begin
            r_state <= S_REDIRECT;
          end
        end
        S_REDIRECT: r_state <= S_RUN;
        default:    r_state <= S_RESET;
      endcase
    end
  end

  // Saturating run length of consecutive PC stalls.
  always_comb begin
    w_wdog_cnt_nxt = '0;
    if (stall_o[c_STG_PC]) begin
      w_wdog_cnt_nxt = (r_wdog_cnt == c_WDOG_MAX) ? c_WDOG_MAX : r_wdog_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_cnt  <= '0;
      r_wdog      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_wdog_cnt <= w_wdog_cnt_nxt;
      if (w_wdog_cnt_nxt == c_WDOG_MAX) begin
        r_wdog <= 1'b1;
      end
      if (stall_o[c_STG_PC]) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign wdog_o      = r_wdog;
  assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire
